if_id_q: RTL and testbench

IF_ID_Q -- requirements
Module: if_id_q

---
 rtl/if_id_q.sv | 184 ++++++++++++++++++
 tb/tb_if_id_q.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_q.sv
// if_id_q: IF/ID pipeline boundary with a 2-entry skid FIFO.
//   Fetch pushes {inst, pc, ppc} when if_valid && if_ready. Decode sees a
//   registered id_* stage. When the FIFO is empty, an accepted entry
//   bypasses the FIFO and reaches id_* one cycle later.
//   stl_mm freezes id_* and dequeue. Pushes are still accepted while room remains.
//   next_invalid flushes everything, including any same-cycle push.
//   rst is synchronous and active low. It has priority over flush and stall.
// Ports:
//   clk, rst                        clock, synchronous active-low reset
//   if_inst/if_pc/if_ppc/if_valid   fetch-side entry and its valid
//   if_ready                        room available (count < 2, not in reset)
//   id_inst/id_pc/id_ppc/id_valid   registered decode-side stage
//   stl_mm                          memory-stage stall
//   next_invalid                    branch redirect flush
//   stat_issue/stat_bubble          issue/bubble cycle counters (only if IF_ID_STAT_EN)
// Optional feature macro: IF_ID_STAT_EN
module if_id_q (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_inst,
   input  logic [31:0] if_pc,
   input  logic [31:0] if_ppc,
   input  logic        if_valid,
   output logic        if_ready,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_ppc,
   output logic        id_valid,
   input  logic        stl_mm,
   input  logic        next_invalid
`ifdef IF_ID_STAT_EN
   ,
   output logic [31:0] stat_issue,
   output logic [31:0] stat_bubble
`endif
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNT_W = 2;

   // FIFO storage. Contents are not reset; count and pointers qualify them.
   logic [XLEN-1:0] inst_mem_q [DEPTH];
   logic [XLEN-1:0] pc_mem_q   [DEPTH];
   logic [XLEN-1:0] ppc_mem_q  [DEPTH];

   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [XLEN-1:0] id_inst_q, id_inst_d;
   logic [XLEN-1:0] id_pc_q,   id_pc_d;
   logic [XLEN-1:0] id_ppc_q,  id_ppc_d;
   logic            id_valid_q, id_valid_d;

   logic push;
   logic fifo_wr;
   logic pop;
   logic issue;

   // The ready output depends only on rst and the registered count.
   assign if_ready = rst && (count_q != CNT_W'(DEPTH));
   assign push     = if_valid && if_ready;

   // An accepted entry goes into the FIFO unless it bypasses straight to id_*.
   // Bypass happens when the FIFO is empty and the stage is not stalled.
   assign fifo_wr  = push && !next_invalid && (stl_mm || (count_q != '0));
   assign pop      = !next_invalid && !stl_mm && (count_q != '0);
   assign issue    = !next_invalid && !stl_mm && ((count_q != '0) || push);

   // Next-state logic for the pointers, the count and the decode stage.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      id_inst_d  = id_inst_q;
      id_pc_d    = id_pc_q;
      id_ppc_d   = id_ppc_q;
      id_valid_d = id_valid_q;

      if (next_invalid) begin
         wr_ptr_d   = 1'b0;
         rd_ptr_d   = 1'b0;
         count_d    = '0;
         id_inst_d  = '0;
         id_pc_d    = '0;
         id_ppc_d   = '0;
         id_valid_d = 1'b0;
      end else begin
         if (fifo_wr) wr_ptr_d = ~wr_ptr_q;
         if (pop)     rd_ptr_d = ~rd_ptr_q;
         unique case ({fifo_wr, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase

         if (!stl_mm) begin
            if (count_q != '0) begin
               id_inst_d  = inst_mem_q[rd_ptr_q];
               id_pc_d    = pc_mem_q[rd_ptr_q];
               id_ppc_d   = ppc_mem_q[rd_ptr_q];
               id_valid_d = 1'b1;
            end else if (push) begin
               id_inst_d  = if_inst;
               id_pc_d    = if_pc;
               id_ppc_d   = if_ppc;
               id_valid_d = 1'b1;
            end else begin
               id_inst_d  = '0;
               id_pc_d    = '0;
               id_ppc_d   = '0;
               id_valid_d = 1'b0;
            end
         end
      end
   end

   // Control and decode-stage registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= '0;
         id_inst_q  <= '0;
         id_pc_q    <= '0;
         id_ppc_q   <= '0;
         id_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         id_inst_q  <= id_inst_d;
         id_pc_q    <= id_pc_d;
         id_ppc_q   <= id_ppc_d;
         id_valid_q <= id_valid_d;
      end
   end

   // FIFO data write. push is already gated low while in reset.
   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         inst_mem_q[wr_ptr_q] <= if_inst;
         pc_mem_q[wr_ptr_q]   <= if_pc;
         ppc_mem_q[wr_ptr_q]  <= if_ppc;
      end
   end

   assign id_inst  = id_inst_q;
   assign id_pc    = id_pc_q;
   assign id_ppc   = id_ppc_q;
   assign id_valid = id_valid_q;

`ifdef IF_ID_STAT_EN
   logic [XLEN-1:0] stat_issue_q, stat_issue_d;
   logic [XLEN-1:0] stat_bubble_q, stat_bubble_d;

   // An issue cycle loads id_valid = 1.
   // A bubble cycle is an unstalled cycle that loads id_valid = 0.
   always_comb begin
      stat_issue_d  = stat_issue_q;
      stat_bubble_d = stat_bubble_q;
      if (issue)                stat_issue_d  = stat_issue_q + XLEN'(1);
      else if (!stl_mm)         stat_bubble_d = stat_bubble_q + XLEN'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_issue_q  <= '0;
         stat_bubble_q <= '0;
      end else begin
         stat_issue_q  <= stat_issue_d;
         stat_bubble_q <= stat_bubble_d;
      end
   end

   assign stat_issue  = stat_issue_q;
   assign stat_bubble = stat_bubble_q;
`else
   logic unused_issue;
   assign unused_issue = issue;
`endif

endmodule

// File: tb/tb_if_id_q.sv
module tb_if_id_q;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_inst, if_pc, if_ppc;
   logic        if_valid, if_ready;
   logic [31:0] id_inst, id_pc, id_ppc;
   logic        id_valid;
   logic        stl_mm, next_invalid;
`ifdef IF_ID_STAT_EN
   logic [31:0] stat_issue, stat_bubble;
`endif

   always #5 clk = ~clk;

   if_id_q dut (
      .clk          (clk),
      .rst          (rst),
      .if_inst      (if_inst),
      .if_pc        (if_pc),
      .if_ppc       (if_ppc),
      .if_valid     (if_valid),
      .if_ready     (if_ready),
      .id_inst      (id_inst),
      .id_pc        (id_pc),
      .id_ppc       (id_ppc),
      .id_valid     (id_valid),
      .stl_mm       (stl_mm),
      .next_invalid (next_invalid)
`ifdef IF_ID_STAT_EN
      ,
      .stat_issue   (stat_issue),
      .stat_bubble  (stat_bubble)
`endif
   );

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] ppc;
   } ent_t;

   // Reference model: a plain queue of waiting entries and the decode stage.
   ent_t        mq[$];
   ent_t        m_id;
   logic        m_valid;
   int unsigned m_issue, m_bubble;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check ready, advance the model, check outputs.
   task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] ppc, input logic stl, input logic ni,
                        input logic r, output logic acc);
      logic exp_rdy;
      ent_t e;
      if_valid = v; if_inst = inst; if_pc = pc; if_ppc = ppc;
      stl_mm = stl; next_invalid = ni; rst = r;
      #1;
      exp_rdy = r && (mq.size() < 2);
      check("if_ready", 32'(if_ready), 32'(exp_rdy));
      acc = v && exp_rdy;
      e.inst = inst; e.pc = pc; e.ppc = ppc;
      @(posedge clk);
      if (!r) begin
         mq.delete();
         m_id = '{32'h0, 32'h0, 32'h0}; m_valid = 1'b0;
         m_issue = 0; m_bubble = 0;
      end else if (ni) begin
         mq.delete();
         m_id = '{32'h0, 32'h0, 32'h0}; m_valid = 1'b0;
         if (!stl) m_bubble++;
      end else if (!stl) begin
         if (mq.size() > 0) begin
            m_id = mq.pop_front(); m_valid = 1'b1; m_issue++;
            if (acc) mq.push_back(e);
         end else if (acc) begin
            m_id = e; m_valid = 1'b1; m_issue++;
         end else begin
            m_id = '{32'h0, 32'h0, 32'h0}; m_valid = 1'b0; m_bubble++;
         end
      end else if (acc) begin
         mq.push_back(e);
      end
      @(negedge clk);
      check("id_inst",  id_inst,  m_id.inst);
      check("id_pc",    id_pc,    m_id.pc);
      check("id_ppc",   id_ppc,   m_id.ppc);
      check("id_valid", 32'(id_valid), 32'(m_valid));
      check("count",    32'(dut.count_q), 32'(mq.size()));
`ifdef IF_ID_STAT_EN
      check("stat_issue",  stat_issue,  m_issue);
      check("stat_bubble", stat_bubble, m_bubble);
`endif
   endtask

   logic        acc;
   logic        off_v;
   logic [31:0] off_pc;
   logic [31:0] off_inst;
   logic        r_stl, r_ni, r_rst;

   initial begin
      mq.delete();
      m_id = '{32'h0, 32'h0, 32'h0}; m_valid = 1'b0; m_issue = 0; m_bubble = 0;
      rst = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0; if_ppc = '0;
      stl_mm = 1'b0; next_invalid = 1'b0;
      @(negedge clk);
      cycle(0, 0, 0, 0, 0, 0, 0, acc);
      cycle(0, 0, 0, 0, 0, 0, 0, acc);
      check("rst_id_valid", 32'(id_valid), 32'h0);

      // First instruction after reset bypasses with one-cycle latency.
      cycle(1, 32'h00100093, 32'h0, 32'h4, 0, 0, 1, acc);
      check("first_inst",  id_inst, 32'h00100093);
      check("first_valid", 32'(id_valid), 32'h1);
      check("first_count", 32'(dut.count_q), 32'h0);

      // Stall with three offered pushes: only two fit.
      cycle(1, 32'h11, 32'h4, 32'h8, 1, 0, 1, acc);
      cycle(1, 32'h12, 32'h8, 32'hC, 1, 0, 1, acc);
      cycle(1, 32'h13, 32'hC, 32'h10, 1, 0, 1, acc);
      check("stall_full_rdy", 32'(if_ready), 32'h0);
      check("stall_frozen",   id_pc, 32'h0);
      cycle(1, 32'h13, 32'hC, 32'h10, 0, 0, 1, acc);
      check("rel_pc4", id_pc, 32'h4);
      cycle(1, 32'h13, 32'hC, 32'h10, 0, 0, 1, acc);
      check("rel_pc8", id_pc, 32'h8);
      check("c_accept", 32'(acc), 32'h1);
      cycle(0, 0, 0, 0, 0, 0, 1, acc);
      check("rel_pcC", id_pc, 32'hC);

      // Flush with a full queue, stalled, and a push offered.
      cycle(1, 32'h20, 32'h10, 32'h14, 1, 0, 1, acc);
      cycle(1, 32'h21, 32'h14, 32'h18, 1, 0, 1, acc);
      cycle(1, 32'h22, 32'h18, 32'h1C, 1, 1, 1, acc);
      check("flush_valid", 32'(id_valid), 32'h0);
      #1 check("flush_rdy", 32'(if_ready), 32'h1);
      cycle(0, 0, 0, 0, 0, 0, 1, acc);
      cycle(0, 0, 0, 0, 0, 0, 1, acc);
      check("no_0x18", 32'(id_valid), 32'h0);

      // Steady flow with one entry held in the queue.
      cycle(1, 32'h30, 32'h1C, 32'h20, 1, 0, 1, acc);
      cycle(1, 32'h31, 32'h20, 32'h24, 0, 0, 1, acc);
      check("flow_1c", id_pc, 32'h1C);
      cycle(1, 32'h32, 32'h24, 32'h28, 0, 0, 1, acc);
      check("flow_20", id_pc, 32'h20);
      cycle(1, 32'h33, 32'h28, 32'h2C, 0, 0, 1, acc);
      check("flow_24", id_pc, 32'h24);
      check("flow_cnt", 32'(dut.count_q), 32'h1);
      cycle(0, 0, 0, 0, 0, 0, 1, acc);
      check("flow_28", id_pc, 32'h28);

      // Reset while stalled with a full queue.
      cycle(1, 32'h40, 32'h30, 32'h34, 1, 0, 1, acc);
      cycle(1, 32'h41, 32'h34, 32'h38, 1, 0, 1, acc);
      cycle(1, 32'h42, 32'h38, 32'h3C, 1, 0, 0, acc);
      check("rst_mid_pc",  id_pc, 32'h0);
      check("rst_mid_rdy", 32'(if_ready), 32'h0);
      cycle(0, 0, 0, 0, 1, 0, 0, acc);
      cycle(0, 0, 0, 0, 0, 0, 1, acc);
      check("rst_rel_rdy", 32'(if_ready), 32'h1);

      // Five issues and two bubbles, then stalls.
      cycle(0, 0, 0, 0, 0, 0, 0, acc);
      for (int i = 0; i < 5; i++)
         cycle(1, 32'h100 + 32'(i), 32'h200 + 32'(i * 4), 32'h204 + 32'(i * 4), 0, 0, 1, acc);
      cycle(0, 0, 0, 0, 0, 0, 1, acc);
      cycle(0, 0, 0, 0, 0, 0, 1, acc);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0, 1, acc);
`ifdef IF_ID_STAT_EN
      check("stat_issue5",  stat_issue,  32'd5);
      check("stat_bubble2", stat_bubble, 32'd2);
`endif

      // Randomized traffic. Upstream holds an offer until it is accepted.
      off_v = 1'b0; off_pc = 32'h1000; off_inst = 32'h0;
      for (int n = 0; n < 3000; n++) begin
         if (!off_v && ($urandom % 10) < 7) begin
            off_v = 1'b1; off_pc = off_pc + 32'h4; off_inst = $urandom;
         end
         r_stl = ($urandom % 10) < 3;
         r_ni  = ($urandom % 20) == 0;
         r_rst = ($urandom % 50) != 0;
         cycle(off_v, off_inst, off_pc, off_pc + 32'h4, r_stl, r_ni, r_rst, acc);
         if (acc || r_ni || !r_rst) off_v = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
